// File: rtl/link_checker.sv
// Link checker: buffers transmitted words in an alignment FIFO, compares them with
// received words, and tracks link lock with a SEARCH/LOCKED state machine.
module link_checker #(
    parameter int MAX_W  = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             clr,
    input  logic [1:0]       dataS,
    input  logic             tx_valid,
    input  logic [MAX_W-1:0] tx_data,
    input  logic             tx_k,
    input  logic             rx_valid,
    input  logic [MAX_W-1:0] rx_data,
    input  logic             rx_k,
    input  logic             rx_invalid,
    output logic             locked,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int LW = $clog2(LOCK_N + 1);
    localparam int EW = $clog2(LOSS_N + 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    localparam logic [LW-1:0]    LOCK_LAST  = LW'(LOCK_N - 1);
    localparam logic [EW-1:0]    LOSS_LAST  = EW'(LOSS_N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    // Casting to MAX_W clips the wider selections when MAX_W is narrow.
    localparam logic [MAX_W-1:0] MASK8  = MAX_W'(8'hFF);
    localparam logic [MAX_W-1:0] MASK16 = MAX_W'(16'hFFFF);
    localparam logic [MAX_W-1:0] MASK32 = MAX_W'(32'hFFFF_FFFF);

    typedef enum logic {SEARCH, LOCKED} stateT;

    stateT            state;
    logic [MAX_W:0]   fifoMem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [CW-1:0]    count;
    logic [LW-1:0]    runCnt;
    logic [EW-1:0]    errRun;
    logic [MAX_W-1:0] widthMask;
    logic [MAX_W:0]   headWord;
    logic             fifoEmpty, fifoFull;
    logic             doPush, doPop, dropEv, underEv;
    logic             isMatch, nonMatch;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        widthMask = '1;
        case (dataS)
            2'b00:   widthMask = MASK8;
            2'b01:   widthMask = MASK16;
            2'b10:   widthMask = MASK32;
            default: widthMask = '1;
        endcase
    end

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_COUNT);
    assign headWord  = fifoMem[rdPtr];
    assign doPop     = enb & rx_valid & ~fifoEmpty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign doPush    = enb & tx_valid & (~fifoFull | doPop);
    assign dropEv    = enb & tx_valid & fifoFull & ~doPop;
    assign underEv   = enb & rx_valid & fifoEmpty;
    assign isMatch   = doPop && !rx_invalid && (headWord[MAX_W] == rx_k)
                       && ((headWord[MAX_W-1:0] & widthMask) == (rx_data & widthMask));
    assign nonMatch  = enb & rx_valid & ~isMatch;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= {tx_k, tx_data & widthMask};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            runCnt    <= '0;
            errRun    <= '0;
            mismatch  <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (enb) begin
            mismatch <= 1'b0;
            case (state)
                SEARCH: begin
                    if (isMatch) begin
                        if (runCnt == LOCK_LAST) begin
                            state  <= LOCKED;
                            runCnt <= '0;
                        end else begin
                            runCnt <= runCnt + LW'(1);
                        end
                    end else if (nonMatch) begin
                        runCnt <= '0;
                    end
                end
                LOCKED: begin
                    if (isMatch) begin
                        word_cnt <= satInc(word_cnt);
                        errRun   <= '0;
                    end else if (nonMatch) begin
                        word_cnt <= satInc(word_cnt);
                        err_cnt  <= satInc(err_cnt);
                        mismatch <= 1'b1;
                        if (errRun == LOSS_LAST) begin
                            state  <= SEARCH;
                            errRun <= '0;
                            runCnt <= '0;
                        end else begin
                            errRun <= errRun + EW'(1);
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
            if (dropEv)  overflow  <= 1'b1;
            if (underEv) underflow <= 1'b1;
            // Clear wins over any increment or flag set in the same cycle.
            if (clr) begin
                err_cnt   <= '0;
                word_cnt  <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
        end else begin
            mismatch <= 1'b0;
        end
    end
endmodule

// File: tb/tb_link_checker.sv
// Bench for link_checker: directed scenarios plus random traffic, checked every cycle
// against a queue-based behavioural model through an expected-output scoreboard.
module tb_link_checker;
    localparam int MAX_W  = 40;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 4;
    localparam int OW     = 2 * CNT_W + 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1, enb = 1'b0, clr = 1'b0;
    logic [1:0]       dataS = 2'b00;
    logic             tx_valid = 1'b0, tx_k = 1'b0;
    logic [MAX_W-1:0] tx_data = '0;
    logic             rx_valid = 1'b0, rx_k = 1'b0, rx_invalid = 1'b0;
    logic [MAX_W-1:0] rx_data = '0;
    logic             locked, mismatch, overflow, underflow;
    logic [CNT_W-1:0] err_cnt, word_cnt;

    link_checker #(.MAX_W(MAX_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
                   .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
        .clk(clk), .rst(rst), .enb(enb), .clr(clr), .dataS(dataS),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_k(tx_k),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_k(rx_k), .rx_invalid(rx_invalid),
        .locked(locked), .mismatch(mismatch), .err_cnt(err_cnt), .word_cnt(word_cnt),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Staged stimulus for the next cycle
    logic             sRst, sEnb, sClr, sTxV, sTxK, sRxV, sRxK, sRxInv;
    logic [1:0]       sDs;
    logic [MAX_W-1:0] sTxD, sRxD;

    // Behavioural model state
    logic [MAX_W:0] fifoQ[$];
    bit             mLocked, mMis, mOvf, mUnf;
    int             mRun, mErrRun, mErr, mWord;

    logic [OW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [MAX_W-1:0] wmask(input logic [1:0] ds);
        int w;
        logic [MAX_W-1:0] m;
        w = (ds == 2'b11) ? MAX_W : (8 << ds);
        if (w > MAX_W) w = MAX_W;
        m = '0;
        for (int b = 0; b < MAX_W; b++) if (b < w) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] randWord();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[MAX_W-1:0];
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic modelStep();
        logic [MAX_W-1:0] m;
        logic [MAX_W:0]   head;
        bit               good;
        mMis = 1'b0;
        if (sRst) begin
            fifoQ.delete();
            mLocked = 1'b0; mRun = 0; mErrRun = 0;
            mErr = 0; mWord = 0; mOvf = 1'b0; mUnf = 1'b0;
            return;
        end
        if (!sEnb) return;
        m = wmask(sDs);
        good = 1'b0;
        if (sRxV) begin
            if (fifoQ.size() > 0) begin
                head = fifoQ.pop_front();
                good = ((head[MAX_W-1:0] & m) == (sRxD & m)) && (head[MAX_W] == sRxK) && !sRxInv;
            end else begin
                mUnf = 1'b1;
            end
        end
        if (sTxV) begin
            if (fifoQ.size() >= DEPTH) mOvf = 1'b1;
            else fifoQ.push_back({sTxK, sTxD & m});
        end
        if (sRxV) begin
            if (!mLocked) begin
                if (good) begin
                    mRun++;
                    if (mRun == LOCK_N) begin mLocked = 1'b1; mRun = 0; end
                end else begin
                    mRun = 0;
                end
            end else begin
                mWord = sat(mWord + 1);
                if (good) begin
                    mErrRun = 0;
                end else begin
                    mErr = sat(mErr + 1);
                    mMis = 1'b1;
                    mErrRun++;
                    if (mErrRun == LOSS_N) begin mLocked = 1'b0; mErrRun = 0; mRun = 0; end
                end
            end
        end
        if (sClr) begin mErr = 0; mWord = 0; mOvf = 1'b0; mUnf = 1'b0; end
    endtask

    task automatic idle();
        sRst = 1'b0; sEnb = 1'b1; sClr = 1'b0;
        sTxV = 1'b0; sTxD = '0; sTxK = 1'b0;
        sRxV = 1'b0; sRxD = '0; sRxK = 1'b0; sRxInv = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        rst = sRst; enb = sEnb; clr = sClr; dataS = sDs;
        tx_valid = sTxV; tx_data = sTxD; tx_k = sTxK;
        rx_valid = sRxV; rx_data = sRxD; rx_k = sRxK; rx_invalid = sRxInv;
        modelStep();
        exp_q.push_back({mLocked, mMis, CNT_W'(mErr), CNT_W'(mWord), mOvf, mUnf});
    endtask

    // Receive the model's head word, with random garbage above the active width.
    task automatic rxFromHead();
        logic [MAX_W-1:0] m;
        m = wmask(sDs);
        if (fifoQ.size() > 0) begin
            sRxV = 1'b1;
            sRxD = (fifoQ[0][MAX_W-1:0] & m) | (randWord() & ~m);
            sRxK = fifoQ[0][MAX_W];
        end
    endtask

    // n words sent one cycle apart, each received one cycle after it was sent.
    task automatic stream(input int n, input logic [1:0] ds, input int badIdx, input bit inv);
        for (int i = 0; i <= n; i++) begin
            idle();
            sDs = ds;
            if (i > 0) begin
                rxFromHead();
                sRxInv = inv;
                if (i - 1 == badIdx) sRxD[0] = ~sRxD[0];
            end
            if (i < n) begin
                sTxV = 1'b1; sTxD = randWord(); sTxK = 1'($urandom_range(0, 1));
            end
            tick();
        end
    endtask

    initial begin : monitor
        logic [OW-1:0] exp, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {locked, mismatch, err_cnt, word_cnt, overflow, underflow};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t got lck=%0b mis=%0b err=%0d wrd=%0d ovf=%0b unf=%0b exp lck=%0b mis=%0b err=%0d wrd=%0d ovf=%0b unf=%0b",
                             $time, act[OW-1], act[OW-2], act[2*CNT_W+1:CNT_W+2], act[CNT_W+1:2], act[1], act[0],
                             exp[OW-1], exp[OW-2], exp[2*CNT_W+1:CNT_W+2], exp[CNT_W+1:2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin : driver
        sDs = 2'b00;
        idle();
        sRst = 1'b1; tick(); tick();
        idle(); tick();
        // Underflow after reset, then cleared
        sRxV = 1'b1; sRxD = randWord(); tick();
        idle(); tick();
        sClr = 1'b1; tick();
        idle(); tick();
        // Lock at 8-bit width
        stream(4, 2'b00, -1, 1'b0);
        idle(); tick();
        // Single 16-bit mismatch while locked
        idle(); sDs = 2'b01; sTxV = 1'b1; sTxD = 40'h12_3456_1235; tick();
        idle(); sRxV = 1'b1; sRxD = 40'h00_0000_1234; tick();
        idle(); tick(); tick();
        // Good words, then consecutive invalid code groups lose lock
        stream(2, 2'b01, -1, 1'b0);
        stream(4, 2'b10, -1, 1'b1);
        idle(); tick();
        // Repeated lock/loss cycles drive both counters into saturation
        for (int r = 0; r < 4; r++) begin
            stream(5, 2'b11, -1, 1'b0);
            stream(4, 2'b11, -1, 1'b1);
        end
        stream(6, 2'b10, 5, 1'b0);
        idle(); sClr = 1'b1; tick();
        // Enable low holds everything
        for (int i = 0; i < 3; i++) begin
            idle(); sEnb = 1'b0; sTxV = 1'b1; sTxD = randWord(); sRxV = 1'b1; sClr = 1'(i == 1); tick();
        end
        // Fill past depth, then push and pop together while full, then drain
        idle(); sRst = 1'b1; tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            idle(); sDs = 2'b10; sTxV = 1'b1; sTxD = randWord(); tick();
        end
        idle(); sTxV = 1'b1; sTxD = randWord(); rxFromHead(); tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); rxFromHead(); tick();
        end
        // Reset mid-stream discards stored words
        for (int i = 0; i < 3; i++) begin
            idle(); sTxV = 1'b1; sTxD = randWord(); tick();
        end
        idle(); sRst = 1'b1; sTxV = 1'b1; sClr = 1'b1; tick();
        idle(); sRxV = 1'b1; sRxD = randWord(); tick();
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            if ($urandom_range(0, 31) == 0) sDs = 2'($urandom_range(0, 3));
            sRst = 1'($urandom_range(0, 299) == 0);
            sEnb = 1'($urandom_range(0, 15) != 0);
            sClr = 1'($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1) begin
                sTxV = 1'b1; sTxD = randWord(); sTxK = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) == 1) begin
                if (fifoQ.size() > 0 && $urandom_range(0, 7) != 0) rxFromHead();
                else begin sRxV = 1'b1; sRxD = randWord(); sRxK = 1'($urandom_range(0, 1)); end
                sRxInv = 1'($urandom_range(0, 31) == 0);
            end
            tick();
        end
        idle(); tick();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/link_checker.md
LINK_CHECKER -- requirements
Module: link_checker

Interface
REQ-001 Parameter MAX_W, default 32, maximum data width in bits (multiple of 8, at least 8).
REQ-002 Parameter DEPTH, default 8, alignment FIFO depth in words (power of two, at least 2).
REQ-003 Parameter CNT_W, default 16, width of the error and word counters.
REQ-004 Parameter LOCK_N, default 4, consecutive matches required to lock; LOSS_N, default 4, consecutive errors required to lose lock.
REQ-005 Port list SHALL be exactly as follows; the block SHALL have one clock, and reset SHALL be synchronous and active-high:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  enable; when 0, all state holds.
- clr  in  1  synchronous clear of counters and sticky flags; FIFO and FSM untouched.
- dataS  in  2  width select: 00 = 8 b, 01 = 16 b, 10 = 32 b, 11 = MAX_W.
- tx_valid  in  1  a word is being sent to the transmitter.
- tx_data  in  MAX_W  data sent to the transmitter.
- tx_k  in  1  control-symbol flag sent with tx_data.
- rx_valid  in  1  the receiver delivers a word.
- rx_data  in  MAX_W  data delivered by the receiver.
- rx_k  in  1  control-symbol flag delivered by the receiver.
- rx_invalid  in  1  receiver reported an invalid code group.
- locked  out  1  FSM is in LOCKED.
- mismatch  out  1  one-cycle pulse on each counted error.
- err_cnt  out  CNT_W  counted errors, saturating.
- word_cnt  out  CNT_W  words compared while LOCKED, saturating.
- overflow  out  1  sticky: a tx word was dropped because the FIFO was full.
- underflow  out  1  sticky: rx_valid arrived while the FIFO was empty.

Function
REQ-006 Width mask: active width W = 8 × 2^dataS, clipped to MAX_W; bits at or above W SHALL be ignored on store and on compare.
REQ-007 FIFO push: on enb and tx_valid, push {tx_k, tx_data masked}.
REQ-008 FIFO full: if full and no pop in the same cycle, drop the word and set overflow; push and pop together when full SHALL succeed with no loss.
REQ-009 FIFO pop: on enb and rx_valid with FIFO non-empty, pop the head; the word is a match when the masked data and the k flag are equal and rx_invalid = 0.
REQ-010 FIFO empty: rx_valid with the FIFO empty SHALL set underflow and count as a non-match; nothing is popped.
REQ-011 FSM states: SEARCH (the reset state), LOCKED.
REQ-012 SEARCH: a match increments the internal run counter; a non-match clears it; run = LOCK_N moves the FSM to LOCKED and clears the run counter.
REQ-013 SEARCH: err_cnt and word_cnt SHALL NOT change and mismatch SHALL stay 0.
REQ-014 LOCKED, match: word_cnt +1, and the consecutive-error counter is cleared.
REQ-015 LOCKED, non-match: err_cnt +1, word_cnt +1, mismatch = 1 in the next cycle, consecutive-error counter +1.
REQ-016 LOCKED: consecutive errors = LOSS_N moves the FSM to SEARCH and clears all run counters.
REQ-017 Latency: all outputs are registered; an rx_valid compare in cycle n is reflected on locked, mismatch, err_cnt and word_cnt in cycle n+1.
REQ-018 Counters saturate at 2^CNT_W − 1 and do not wrap.
REQ-019 enb = 0: FIFO, FSM, counters and flags hold, and mismatch is 0.
REQ-020 clr = 1 (priority below rst, above the increments of the same cycle): err_cnt = 0, word_cnt = 0, overflow = 0, underflow = 0.
REQ-021 A dataS change takes effect at the next push or compare; words already stored keep the mask applied at push time.

Reset
REQ-022 With rst = 1 at a rising edge, the next cycle SHALL show: FIFO empty, FSM in SEARCH, run counters 0, locked = 0, mismatch = 0, err_cnt = 0, word_cnt = 0, overflow = 0, underflow = 0.
REQ-023 rst SHALL override enb, clr and all data inputs; a reset mid-stream discards all FIFO contents.

Verification
REQ-024 dataS = 00; 4 identical tx/rx words sent one cycle apart -> locked = 1 in the cycle after the 4th compare; err_cnt = 0.
REQ-025 Locked at dataS = 01; one rx word 0x1234 against expected 0x1235 -> mismatch pulse of one cycle, err_cnt = 1, locked stays 1.
REQ-026 Locked; 4 consecutive rx_invalid = 1 -> err_cnt = 4, locked = 0 in the cycle after the 4th compare.
REQ-027 DEPTH = 8; 9 tx pushes with no rx -> overflow = 1; the 9th word is lost; a push and pop together while full -> no further drop.
REQ-028 rx_valid with the FIFO empty after reset -> underflow = 1, err_cnt = 0 (FSM in SEARCH); clr = 1 -> underflow = 0.
REQ-029 CNT_W = 4, locked, 20 errors with LOSS_N = 32 -> err_cnt holds at 15; then rst -> all outputs 0 in the next cycle.
